// File: rtl/hue_wheel_pkg.sv
// rtl/hue_wheel_pkg.sv - segment encoding and colour-wheel duty map for hue_wheel
package hue_wheel_pkg;

    typedef enum logic [2:0] {
        SEG_RG = 3'd0,
        SEG_GR = 3'd1,
        SEG_GB = 3'd2,
        SEG_BG = 3'd3,
        SEG_BR = 3'd4,
        SEG_RB = 3'd5
    } seg_t;

    localparam int          NUM_SEGS = 6;
    localparam logic [2:0]  SEG_LAST = 3'(NUM_SEGS - 1);

    // Wide enough for any PWM_INTERVAL the block is expected to see; callers truncate.
    localparam int DUTY_W = 16;

    typedef struct packed {
        logic [DUTY_W-1:0] r;
        logic [DUTY_W-1:0] g;
        logic [DUTY_W-1:0] b;
    } rgb_t;

    function automatic rgb_t seg_duty(input seg_t seg,
                                      input logic [DUTY_W-1:0] phase,
                                      input logic [DUTY_W-1:0] full);
        rgb_t              c;
        logic [DUTY_W-1:0] dn;
        dn = full - phase;
        c  = '0;
        case (seg)
            SEG_RG: begin c.r = full;  c.g = phase; end
            SEG_GR: begin c.r = dn;    c.g = full;  end
            SEG_GB: begin c.g = full;  c.b = phase; end
            SEG_BG: begin c.g = dn;    c.b = full;  end
            SEG_BR: begin c.r = phase; c.b = full;  end
            SEG_RB: begin c.r = full;  c.b = dn;    end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hue_wheel_step_timer.sv
// rtl/hue_wheel_step_timer.sv - step_timer: enable-gated prescaler emitting a one-cycle step strobe
module step_timer #(
    parameter int STEP_INTERVAL = 2000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic step_o
);

    localparam int             CW   = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
    localparam logic [CW-1:0]  LAST = CW'(STEP_INTERVAL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign step_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hue_wheel.sv
// rtl/hue_wheel.sv - rainbow RGB duty generator walking six linear colour-wheel segments
// Define HUE_WHEEL_DIR_EN to add the dir input for reverse rotation.
module hue_wheel
    import hue_wheel_pkg::*;
#(
    parameter int  PWM_INTERVAL  = 1200,
    parameter int  STEP_INTERVAL = 2000,
    parameter int  RAMP_STEP     = 2,
    localparam int DW            = $clog2(PWM_INTERVAL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
`ifdef HUE_WHEEL_DIR_EN
    input  logic          dir,
`endif
    output logic [DW-1:0] duty_r,
    output logic [DW-1:0] duty_g,
    output logic [DW-1:0] duty_b,
    output logic [2:0]    seg,
    output logic          wrap
);

    localparam logic [DW-1:0] FULL   = DW'(PWM_INTERVAL);
    localparam logic [DW:0]   FULL_W = (DW+1)'(PWM_INTERVAL);
    localparam logic [DW:0]   STEP_W = (DW+1)'(RAMP_STEP);

    logic          step;
    logic          advance;
    logic [DW:0]   nxt;
    seg_t          seg_q, seg_d;
    logic [DW-1:0] ramp_q, ramp_d;
    logic          wrap_q, wrap_d;
    logic [DW-1:0] phase;
    rgb_t          rgb;
    logic [DW-1:0] duty_r_q, duty_g_q, duty_b_q;

    step_timer #(
        .STEP_INTERVAL(STEP_INTERVAL)
    ) u_step_timer (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en),
        .step_o (step)
    );

    // One extra bit so the last partial step is detected rather than wrapping.
    assign nxt     = {1'b0, ramp_q} + STEP_W;
    assign advance = step && (nxt >= FULL_W);

    always_comb begin
        seg_d  = seg_q;
        ramp_d = ramp_q;
        wrap_d = 1'b0;
        if (step) begin
            if (!advance) begin
                ramp_d = nxt[DW-1:0];
            end else begin
                ramp_d = '0;
`ifdef HUE_WHEEL_DIR_EN
                // The incoming dir picks the direction of this advance and is latched with it.
                if (dir) begin
                    seg_d  = (seg_q == SEG_RG) ? SEG_RB : seg_t'(seg_q - 3'd1);
                    wrap_d = (seg_q == SEG_RG);
                end else
`endif
                begin
                    seg_d  = (seg_q == SEG_LAST) ? SEG_RG : seg_t'(seg_q + 3'd1);
                    wrap_d = (seg_q == SEG_LAST);
                end
            end
        end
    end

`ifdef HUE_WHEEL_DIR_EN
    logic dir_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q <= 1'b0;
        end else if (advance) begin
            dir_q <= dir;
        end
    end

    assign phase = dir_q ? (FULL - ramp_q) : ramp_q;
`else
    assign phase = ramp_q;
`endif

    always_comb begin
        rgb = seg_duty(seg_q, DUTY_W'(phase), DUTY_W'(PWM_INTERVAL));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q    <= SEG_RG;
            ramp_q   <= '0;
            wrap_q   <= 1'b0;
            duty_r_q <= FULL;
            duty_g_q <= '0;
            duty_b_q <= '0;
        end else begin
            seg_q    <= seg_d;
            ramp_q   <= ramp_d;
            wrap_q   <= wrap_d;
            duty_r_q <= DW'(rgb.r);
            duty_g_q <= DW'(rgb.g);
            duty_b_q <= DW'(rgb.b);
        end
    end

    assign duty_r = duty_r_q;
    assign duty_g = duty_g_q;
    assign duty_b = duty_b_q;
    assign seg    = seg_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_hue_wheel.sv
// tb/tb_hue_wheel.sv - directed self-checking bench for hue_wheel (F=12, 4-cycle steps, ramp steps 3 and 5)
module tb_hue_wheel;

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    logic [3:0] ra, ga, ba, rb, gb, bb;
    logic [2:0] sa, sb;
    logic       wa, wb;

    hue_wheel #(.PWM_INTERVAL(12), .STEP_INTERVAL(4), .RAMP_STEP(3)) u_dut_a (
        .clk(clk), .rst(rst), .en(en),
        .duty_r(ra), .duty_g(ga), .duty_b(ba), .seg(sa), .wrap(wa)
    );

    hue_wheel #(.PWM_INTERVAL(12), .STEP_INTERVAL(4), .RAMP_STEP(5)) u_dut_b (
        .clk(clk), .rst(rst), .en(en),
        .duty_r(rb), .duty_g(gb), .duty_b(bb), .seg(sb), .wrap(wb)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int act   = 0;
    int pa_seg = 0, pa_ramp = 0, pb_seg = 0, pb_ramp = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (active cycle %0d)", tag, got, want, act);
        end
    endtask

    // Colour wheel table written out directly: {r,g,b} 4 bits each, F = 12.
    function automatic logic [11:0] duty_of(input int s, input int up);
        int r, g, b, dn;
        dn = 12 - up;
        r = 0; g = 0; b = 0;
        case (s)
            0: begin r = 12; g = up; end
            1: begin r = dn; g = 12; end
            2: begin g = 12; b = up; end
            3: begin g = dn; b = 12; end
            4: begin r = up; b = 12; end
            5: begin r = 12; b = dn; end
            default: ;
        endcase
        return {r[3:0], g[3:0], b[3:0]};
    endfunction

    task automatic check_unit(input string name, input int rs, input logic en_v,
                              input logic [2:0] s_got, input logic w_got,
                              input logic [11:0] d_got,
                              inout int p_seg, inout int p_ramp);
        int k, steps, seg_e, ramp_e;
        logic wrap_e;
        k      = (12 + rs - 1) / rs;
        steps  = act / 4;
        seg_e  = (steps / k) % 6;
        ramp_e = (steps % k) * rs;
        wrap_e = en_v && (act > 0) && (act % 4 == 0) && (steps % (6 * k) == 0);
        expect_eq({name, "_seg_wrap"}, {28'd0, s_got, w_got}, {28'd0, 3'(seg_e), wrap_e});
        expect_eq({name, "_duty"}, {20'd0, d_got}, {20'd0, duty_of(p_seg, p_ramp)});
        p_seg  = seg_e;
        p_ramp = ramp_e;
    endtask

    task automatic cycle(input logic en_v);
        @(negedge clk);
        en = en_v;
        @(posedge clk);
        if (en_v) act++;
        #1;
        check_unit("A", 3, en_v, sa, wa, {ra, ga, ba}, pa_seg, pa_ramp);
        check_unit("B", 5, en_v, sb, wb, {rb, gb, bb}, pb_seg, pb_ramp);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_eq("rst_duty_a", {20'd0, ra, ga, ba}, 32'h0000_0C00);
        expect_eq("rst_seg_a",  {29'd0, sa}, 32'd0);
        expect_eq("rst_wrap_a", {31'd0, wa}, 32'd0);
        expect_eq("rst_duty_b", {20'd0, rb, gb, bb}, 32'h0000_0C00);

        @(negedge clk);
        rst = 1'b0;

        // Full revolution of A (96 cycles); B wraps at 72.
        repeat (96) cycle(1'b1);
        expect_eq("rev_end_seg_a", {29'd0, sa}, 32'd0);

        // Walk into the middle of seg2, then freeze for 20 cycles.
        repeat (38) cycle(1'b1);
        expect_eq("mid_seg2_a", {29'd0, sa}, 32'd2);
        expect_eq("mid_seg2_g_a", {28'd0, ga}, 32'd12);
        repeat (20) cycle(1'b0);
        expect_eq("frozen_seg_a", {29'd0, sa}, 32'd2);

        // Resume and land in seg4 with ramp 6 (act 169 -> step 42).
        repeat (35) cycle(1'b1);
        expect_eq("pre_rst_seg_a", {29'd0, sa}, 32'd4);
        expect_eq("pre_rst_r_a", {28'd0, ra}, 32'd6);

        #2;
        rst = 1'b1;
        #1;
        expect_eq("async_rst_duty_a", {20'd0, ra, ga, ba}, 32'h0000_0C00);
        expect_eq("async_rst_seg_a",  {29'd0, sa}, 32'd0);
        expect_eq("async_rst_wrap_a", {31'd0, wa}, 32'd0);
        expect_eq("async_rst_duty_b", {20'd0, rb, gb, bb}, 32'h0000_0C00);
        expect_eq("async_rst_seg_b",  {29'd0, sb}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
